// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel payload types and colour expansion for the VGA display end.
package vga_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int unsigned V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned FLAG_W = 3;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } vga_flags_t;

    // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
    function automatic rgb888_t rgb332_to_888(input rgb332_t p);
        rgb888_t q;
        q.r = {p.r, p.r, p.r[2:1]};
        q.g = {p.g, p.g, p.g[2:1]};
        q.b = {p.b, p.b, p.b, p.b};
        return q;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register aligning timing flags with the drawers' pixel latency.
module vga_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_controller.sv
// Free-running VGA timing generator: issues pixel coordinates, aligns sync/blank with returned RGB.
module vga_sync_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT     = H_FRONT_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BACK      = H_BACK_DEF,
    parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT     = V_FRONT_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BACK      = V_BACK_DEF,
    parameter int unsigned PIX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hsyncN,
    output logic        vsyncN,
    output logic        blankN,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;
    vga_flags_t       flags_c;
    vga_flags_t       flags_d;
    rgb888_t          pix_c;

    assign h_last = (h_cnt == CNT_W'(H_TOT - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOT - 1));

    // Raster counters; vertical advances on the last clock of each line.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    assign pixelX       = h_cnt;
    assign pixelY       = v_cnt;
    assign startOfFrame = (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        flags_c     = '0;
        flags_c.vis = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
        flags_c.hs  = (h_cnt >= CNT_W'(HS_FIRST)) && (h_cnt <= CNT_W'(HS_LAST));
        flags_c.vs  = (v_cnt >= CNT_W'(VS_FIRST)) && (v_cnt <= CNT_W'(VS_LAST));
    end

    vga_delay_line #(
        .WIDTH     (FLAG_W),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL (FLAG_W'(0))
    ) u_flag_dly (
        .clk    (clk),
        .resetN (resetN),
        .din    (flags_c),
        .dout   (flags_d)
    );

    assign pix_c = rgb332_to_888(rgb332_t'(RGB_in));

    // Pin register: colour is blanked outside the aligned visible window.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hsyncN <= 1'b1;
            vsyncN <= 1'b1;
            blankN <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            hsyncN <= ~flags_d.hs;
            vsyncN <= ~flags_d.vs;
            blankN <= flags_d.vis;
            red    <= flags_d.vis ? pix_c.r : 8'h00;
            green  <= flags_d.vis ? pix_c.g : 8'h00;
            blue   <= flags_d.vis ? pix_c.b : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench: full-size timing at latency 1, reduced raster at latency 3 for frame-level checks.
module tb_vga_sync_controller;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    // Full-size instance, latency 1
    logic        resetN;
    logic [7:0]  rgb_in;
    logic [10:0] pixel_x, pixel_y;
    logic        sof, hs_n, vs_n, blank_n;
    logic [7:0]  red, green, blue;

    // Reduced raster (25 x 13), latency 3
    logic        resetN_s;
    logic [7:0]  rgb_in_s;
    logic [10:0] pixel_x_s, pixel_y_s;
    logic        sof_s, hs_n_s, vs_n_s, blank_n_s;
    logic [7:0]  red_s, green_s, blue_s;

    vga_sync_controller u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .RGB_in       (rgb_in),
        .pixelX       (pixel_x),
        .pixelY       (pixel_y),
        .startOfFrame (sof),
        .hsyncN       (hs_n),
        .vsyncN       (vs_n),
        .blankN       (blank_n),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    vga_sync_controller #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .PIX_LATENCY(3)
    ) u_small (
        .clk          (clk),
        .resetN       (resetN_s),
        .RGB_in       (rgb_in_s),
        .pixelX       (pixel_x_s),
        .pixelY       (pixel_y_s),
        .startOfFrame (sof_s),
        .hsyncN       (hs_n_s),
        .vsyncN       (vs_n_s),
        .blankN       (blank_n_s),
        .red          (red_s),
        .green        (green_s),
        .blue         (blue_s)
    );

    // Drawer models: return pixelX[7:0] after one (full-size) or three (reduced) clocks.
    logic       drawer_en;
    logic [7:0] rgb_force;
    logic [7:0] drawer_q;
    logic [7:0] dr_s [3];

    always @(posedge clk) begin
        drawer_q <= pixel_x[7:0];
        dr_s[0]  <= pixel_x_s[7:0];
        dr_s[1]  <= dr_s[0];
        dr_s[2]  <= dr_s[1];
    end

    assign rgb_in   = drawer_en ? drawer_q : rgb_force;
    assign rgb_in_s = dr_s[2];

    typedef struct {
        logic [7:0] rgb;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int p, x, y;
        int hs_fall0, hs_fall1, hs_rise0, vs_low;
        int sof_k0, sof_k1, vs_fall, vs_rise, hsf_s, hsr_s;
        logic hs_prev, vs_prev;

        vec[0] = '{8'b101_011_10, 8'hB6, 8'h6D, 8'hAA};
        vec[1] = '{8'hFF,         8'hFF, 8'hFF, 8'hFF};
        vec[2] = '{8'h00,         8'h00, 8'h00, 8'h00};
        vec[3] = '{8'b100_000_01, 8'h92, 8'h00, 8'h55};
        vec[4] = '{8'b010_111_00, 8'h49, 8'hFF, 8'h00};
        vec[5] = '{8'b001_100_11, 8'h24, 8'h92, 8'hFF};

        resetN    = 1'b0;
        resetN_s  = 1'b0;
        drawer_en = 1'b0;
        rgb_force = vec[0].rgb;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_px",    32'(pixel_x), 0);
        chk("rst_py",    32'(pixel_y), 0);
        chk("rst_sof",   32'(sof), 1);
        chk("rst_hsync", 32'(hs_n), 1);
        chk("rst_vsync", 32'(vs_n), 1);
        chk("rst_blank", 32'(blank_n), 0);
        chk("rst_rgb",   32'({red, green, blue}), 0);

        resetN = 1'b1;
        k = 0;
        step(1);
        chk("rel_px1",    32'(pixel_x), 1);
        chk("rel_sof1",   32'(sof), 0);
        chk("rel_blank1", 32'(blank_n), 0);
        chk("rel_rgb1",   32'({red, green, blue}), 0);

        // Colour expansion table, held constant across visible pixels of line 0
        for (int i = 0; i < NV; i++) begin
            rgb_force = vec[i].rgb;
            step(i == 0 ? 1 : 2);
            chk("exp_blank", 32'(blank_n), 1);
            chk("exp_red",   32'(red),   32'(vec[i].r));
            chk("exp_green", 32'(green), 32'(vec[i].g));
            chk("exp_blue",  32'(blue),  32'(vec[i].b));
        end

        // Line timing and alignment with the latency-1 drawer
        drawer_en = 1'b1;
        hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1; vs_low = 0;
        hs_prev = hs_n;
        for (int c = 0; c < 1800; c++) begin
            step(1);
            p = k - 2;
            x = p % 800;
            y = p / 800;
            if (y == 0 && x == 100) begin
                chk("al_red100",   32'(red),   32'h6D);
                chk("al_green100", 32'(green), 32'h24);
                chk("al_blue100",  32'(blue),  32'h00);
            end
            if (y == 0 && x == 639) begin
                chk("al_blank639", 32'(blank_n), 1);
                chk("al_rgb639",   32'({red, green, blue}), 32'h6DFFFF);
            end
            if (y == 0 && x == 640) begin
                chk("al_blank640", 32'(blank_n), 0);
                chk("al_rgb640",   32'({red, green, blue}), 0);
            end
            if (k == 800) begin
                chk("wrap_px", 32'(pixel_x), 0);
                chk("wrap_py", 32'(pixel_y), 1);
            end
            if (hs_prev && !hs_n) begin
                if (hs_fall0 < 0) hs_fall0 = k;
                else if (hs_fall1 < 0) hs_fall1 = k;
            end
            if (!hs_prev && hs_n && hs_rise0 < 0) hs_rise0 = k;
            if (!vs_n) vs_low++;
            hs_prev = hs_n;
        end
        chk("hs_start",  32'(hs_fall0), 658);
        chk("hs_width",  32'(hs_rise0 - hs_fall0), 96);
        chk("hs_period", 32'(hs_fall1 - hs_fall0), 800);
        chk("vs_idle",   32'(vs_low), 0);

        // Mid-frame reset at pixel (320,2)
        step(1920 - k);
        chk("mid_px",    32'(pixel_x), 320);
        chk("mid_py",    32'(pixel_y), 2);
        chk("mid_blank", 32'(blank_n), 1);
        chk("mid_rgb",   32'({red, green, blue}), 32'h24FFAA);
        resetN = 1'b0;
        #1;
        chk("mrst_px",    32'(pixel_x), 0);
        chk("mrst_py",    32'(pixel_y), 0);
        chk("mrst_sof",   32'(sof), 1);
        chk("mrst_hsync", 32'(hs_n), 1);
        chk("mrst_vsync", 32'(vs_n), 1);
        chk("mrst_blank", 32'(blank_n), 0);
        chk("mrst_rgb",   32'({red, green, blue}), 0);
        @(negedge clk);
        @(negedge clk);
        chk("mrst_hold_px", 32'(pixel_x), 0);
        resetN = 1'b1;
        k = 0;
        step(1);
        chk("mrel_blank1", 32'(blank_n), 0);
        chk("mrel_px1",    32'(pixel_x), 1);
        step(1);
        chk("mrel_blank2", 32'(blank_n), 1);
        chk("mrel_px2",    32'(pixel_x), 2);
        step(5);
        chk("mrel_rgb5",   32'({red, green, blue}), 32'h002455);

        // Reduced raster, latency 3: frame timing and alignment
        resetN_s = 1'b1;
        k = 0;
        sof_k0 = -1; sof_k1 = -1; vs_fall = -1; vs_rise = -1; hsf_s = -1; hsr_s = -1;
        hs_prev = hs_n_s;
        vs_prev = vs_n_s;
        for (int c = 0; c < 700; c++) begin
            step(1);
            if (k == 3) chk("s_blank3", 32'(blank_n_s), 0);
            if (k == 4) chk("s_blank4", 32'(blank_n_s), 1);
            p = k - 4;
            if (p >= 0 && p < 325) begin
                x = p % 25;
                y = p / 25;
                if (y == 0 && x == 15) begin
                    chk("s_blank15", 32'(blank_n_s), 1);
                    chk("s_rgb15",   32'({red_s, green_s, blue_s}), 32'h006DFF);
                end
                if (y == 0 && x == 16) begin
                    chk("s_blank16", 32'(blank_n_s), 0);
                    chk("s_rgb16",   32'({red_s, green_s, blue_s}), 0);
                end
                if (y == 6 && x == 3) chk("s_vblank", 32'(blank_n_s), 0);
            end
            if (sof_s) begin
                if (sof_k0 < 0) sof_k0 = k;
                else if (sof_k1 < 0) sof_k1 = k;
            end
            if (hs_prev && !hs_n_s && hsf_s < 0) hsf_s = k;
            if (!hs_prev && hs_n_s && hsr_s < 0) hsr_s = k;
            if (vs_prev && !vs_n_s && vs_fall < 0) vs_fall = k;
            if (!vs_prev && vs_n_s && vs_rise < 0) vs_rise = k;
            hs_prev = hs_n_s;
            vs_prev = vs_n_s;
        end
        chk("s_sof0",     32'(sof_k0), 325);
        chk("s_sof1",     32'(sof_k1), 650);
        chk("s_hs_start", 32'(hsf_s), 22);
        chk("s_hs_width", 32'(hsr_s - hsf_s), 4);
        chk("s_vs_start", 32'(vs_fall), 204);
        chk("s_vs_width", 32'(vs_rise - vs_fall), 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
